innerproduct_mac: RTL and testbench

Streaming, parametrised successor to the fixed combinational 81-term inner product. It accepts one pixel per handshake and multiply-accumulates it against N_CH on-chip coefficient sets in parallel, producing N_CH logistic-regression hidden values per frame. The bias term is added as theta[0] scaled by 2^BIAS_SHIFT. It sits between the line buffer (pixel source) and the sigmoid/compare stage (result sink), and replaces N_FEAT parallel multipliers per class with one pipelined MAC per class.

---
 rtl/innerproduct_mac.sv | 149 ++++++++++++++
 tb/tb_innerproduct_mac.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/innerproduct_mac.sv
// Streaming inner-product MAC: one pixel per handshake, N_CH coefficient sets in parallel.
// Bias is theta[c][0] << BIAS_SHIFT; all accumulation wraps modulo 2^ACC_W.
//
// state | meaning
// IDLE  | waiting for beat 1 of a frame; coefficient writes allowed
// ACC   | accepting beats 2..N_FEAT, accumulating the previous product
// DRAIN | last product folded into the accumulator
// DONE  | result presented until res_ready
module innerproduct_mac #(
    parameter int N_FEAT     = 80,
    parameter int X_W        = 7,
    parameter int TH_W       = 32,
    parameter int ACC_W      = 32,
    parameter int N_CH       = 1,
    parameter int BIAS_SHIFT = 16,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW        = $clog2(N_FEAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coef_we,
    input  logic [CH_W-1:0]       coef_ch,
    input  logic [AW-1:0]         coef_addr,
    input  logic [TH_W-1:0]       coef_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [X_W-1:0]        x_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [N_CH*ACC_W-1:0] res_data,
    output logic                  busy
);

    localparam int PW = X_W + 1 + TH_W;
    localparam int MW = (PW > ACC_W) ? PW : ACC_W;
    localparam int BW = ((TH_W + BIAS_SHIFT) > ACC_W) ? (TH_W + BIAS_SHIFT) : ACC_W;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             pvld_q, pvld_d;
    logic [ACC_W-1:0] acc_q  [N_CH];
    logic [ACC_W-1:0] acc_d  [N_CH];
    logic [ACC_W-1:0] prod_q [N_CH];
    logic [ACC_W-1:0] prod_d [N_CH];
    logic [ACC_W-1:0] prod_new [N_CH];
    logic [ACC_W-1:0] bias_new [N_CH];
    logic [TH_W-1:0]  coef_q [N_CH][N_FEAT+1];
    logic [AW-1:0]    k_idx;
    logic             accept;
    logic             coef_wr_ok;

    assign k_idx      = cnt_q + AW'(1);
    assign busy       = (state_q != IDLE);
    assign coef_wr_ok = coef_we && (state_q == IDLE) && !x_valid;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            prod_new[c] = ACC_W'(MW'($signed({1'b0, x_data})) * MW'($signed(coef_q[c][k_idx])));
            bias_new[c] = ACC_W'(BW'($signed(coef_q[c][0])) <<< BIAS_SHIFT);
        end
    end

    // Out-of-range channel or address values match no slot and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++)
                for (int a = 0; a <= N_FEAT; a++)
                    coef_q[c][a] <= '0;
        end else if (coef_wr_ok) begin
            for (int c = 0; c < N_CH; c++)
                for (int a = 0; a <= N_FEAT; a++)
                    if (coef_ch == CH_W'(c) && coef_addr == AW'(a))
                        coef_q[c][a] <= coef_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pvld_d    = pvld_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        x_ready   = (state_q == IDLE) || (state_q == ACC);
        res_valid = 1'b0;
        accept    = x_valid && x_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = bias_new;
                    prod_d  = prod_new;
                    pvld_d  = 1'b1;
                    cnt_d   = k_idx;
                    state_d = (N_FEAT == 1) ? DRAIN : ACC;
                end
            end
            ACC: begin
                if (pvld_q)
                    for (int c = 0; c < N_CH; c++) acc_d[c] = acc_q[c] + prod_q[c];
                if (accept) begin
                    prod_d = prod_new;
                    pvld_d = 1'b1;
                    cnt_d  = k_idx;
                    if (k_idx == AW'(N_FEAT)) state_d = DRAIN;
                end else begin
                    pvld_d = 1'b0;
                end
            end
            DRAIN: begin
                if (pvld_q)
                    for (int c = 0; c < N_CH; c++) acc_d[c] = acc_q[c] + prod_q[c];
                pvld_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pvld_q  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c]  <= '0;
                prod_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pvld_q  <= pvld_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_res
        assign res_data[c*ACC_W +: ACC_W] = acc_q[c];
    end

endmodule

// File: tb/tb_innerproduct_mac.sv
// Bench for innerproduct_mac: default-parameter DUT checked every cycle against a frame-level
// model (coefficient table + beat sum + fixed result latency), plus a 2-channel N_FEAT=4 instance.
module tb_innerproduct_mac;

    localparam int N = 80;

    logic        clk = 1'b0;
    logic        rst;
    logic        coef_we;
    logic [0:0]  coef_ch;
    logic [6:0]  coef_addr;
    logic [31:0] coef_data;
    logic        x_valid;
    logic        x_ready;
    logic [6:0]  x_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    logic        coef_we2;
    logic [0:0]  coef_ch2;
    logic [2:0]  coef_addr2;
    logic [31:0] coef_data2;
    logic        x_valid2;
    logic        x_ready2;
    logic [6:0]  x_data2;
    logic        res_valid2;
    logic        res_ready2;
    logic [63:0] res_data2;
    logic        busy2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    innerproduct_mac u_dut (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_ch(coef_ch), .coef_addr(coef_addr),
        .coef_data(coef_data), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    innerproduct_mac #(.N_FEAT(4), .N_CH(2)) u_dut2 (
        .clk(clk), .rst(rst), .coef_we(coef_we2), .coef_ch(coef_ch2), .coef_addr(coef_addr2),
        .coef_data(coef_data2), .x_valid(x_valid2), .x_ready(x_ready2), .x_data(x_data2),
        .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2), .busy(busy2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: coefficient table, running frame sum, pending result and its due cycle.
    logic [31:0] th [0:N];
    int          fr_n = 0;
    longint      fr_sum = 0;
    bit          pend = 0;
    logic [31:0] pend_val = '0;
    int          last_cyc = 0;
    int          cyc = 0;
    bit          fresh = 1;

    always @(negedge clk) begin
        bit exp_xr, exp_rv, exp_busy;
        cyc++;
        if (rst) begin
            chk("rst_x_ready", x_ready, 1);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_busy", busy, 0);
            for (int a = 0; a <= N; a++) th[a] = '0;
            fr_n  = 0;
            pend  = 0;
            fresh = 1;
        end else begin
            exp_xr   = !pend;
            exp_rv   = pend && (cyc >= last_cyc + 2);
            exp_busy = pend || (fr_n > 0);
            chk("x_ready", x_ready, exp_xr);
            chk("res_valid", res_valid, exp_rv);
            chk("busy", busy, exp_busy);
            if (exp_rv) chk("res_data", res_data, pend_val);
            if (fresh) chk("res_data_clear", res_data, 0);
            if (x_valid && exp_xr) begin
                if (fr_n == 0) fr_sum = longint'($signed(th[0])) <<< 16;
                fr_n++;
                fr_sum += longint'(x_data) * longint'($signed(th[fr_n]));
                fresh = 0;
                if (fr_n == N) begin
                    pend     = 1;
                    pend_val = fr_sum[31:0];
                    last_cyc = cyc;
                    fr_n     = 0;
                end
            end
            if (exp_rv && res_ready) pend = 0;
            if (coef_we && !exp_busy && !x_valid && coef_ch == 0 && int'(coef_addr) <= N)
                th[coef_addr] = coef_data;
        end
    end

    logic [6:0] xs [1:N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [0:0] ch, input logic [6:0] addr, input logic [31:0] d);
        coef_we = 1'b1; coef_ch = ch; coef_addr = addr; coef_data = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic beat(input logic [6:0] x);
        bit ok;
        int n = 0;
        x_valid = 1'b1;
        x_data  = x;
        do begin
            @(negedge clk);
            ok = x_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        x_valid = 1'b0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: x_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic send_frame(input int gap_pct);
        for (int k = 1; k <= N; k++) begin
            if (k > 1 && int'($urandom_range(99)) < gap_pct) begin
                if ($urandom_range(1) == 1) write_coef(0, 7'($urandom_range(80)), $urandom);
                else repeat ($urandom_range(1, 3)) tick();
            end
            beat(xs[k]);
        end
    endtask

    task automatic get_result(input int hold, input bit do_chk, input logic [31:0] exp,
                              input string nm, output int lat);
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: res_valid 0 after %0d cycles, required 1", nm, lat);
            return;
        end
        if (do_chk) chk(nm, res_data, exp);
        tick();
        repeat (hold) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic write2(input logic [0:0] ch, input logic [2:0] a, input logic [31:0] d);
        coef_we2 = 1'b1; coef_ch2 = ch; coef_addr2 = a; coef_data2 = d;
        tick();
        coef_we2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int th2 [2][5];
        int xv2 [4];
        rst = 1'b0; coef_we = 0; coef_ch = 0; coef_addr = 0; coef_data = 0;
        x_valid = 0; x_data = 0; res_ready = 0;
        coef_we2 = 0; coef_ch2 = 0; coef_addr2 = 0; coef_data2 = 0;
        x_valid2 = 0; x_data2 = 0; res_ready2 = 0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Partial frame cut off by reset, then an all-zero-coefficient frame.
        for (int k = 0; k < 10; k++) beat(7'($urandom));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        for (int k = 1; k <= N; k++) xs[k] = 7'($urandom);
        send_frame(0);
        get_result(0, 1, 32'h0, "zero_coef", lat);

        // Sign and wrap.
        write_coef(0, 1, 32'hFFFF_FFFD);
        for (int k = 1; k <= N; k++) xs[k] = 7'd0;
        xs[1] = 7'd127;
        send_frame(0);
        get_result(1, 1, 32'hFFFF_FE83, "sign_wrap", lat);

        // Unit sum with continuous x_valid; latency two cycles after the last beat.
        for (int a = 0; a <= N; a++) write_coef(0, 7'(a), 32'd1);
        for (int k = 1; k <= N; k++) xs[k] = 7'd1;
        send_frame(0);
        get_result(0, 1, 32'd65616, "unit_sum", lat);
        chk("unit_latency", 64'(lat), 64'd2);

        // Writes while busy, or with x_valid high, are dropped; idle write applies.
        for (int k = 1; k <= 40; k++) beat(7'd1);
        write_coef(0, 0, 32'd100);
        for (int k = 41; k <= N; k++) beat(7'd1);
        get_result(2, 1, 32'd65616, "blocked_write", lat);
        coef_we = 1'b1; coef_ch = 0; coef_addr = 0; coef_data = 32'd7;
        beat(7'd1);
        coef_we = 1'b0;
        for (int k = 2; k <= N; k++) beat(7'd1);
        get_result(0, 1, 32'd65616, "old_bias", lat);
        write_coef(0, 0, 32'd100);
        send_frame(0);
        get_result(0, 1, 32'd6553680, "new_bias", lat);

        // Random coefficients, pixels, gaps and result backpressure.
        for (int a = 0; a <= N; a++) write_coef(0, 7'(a), $urandom);
        write_coef(1, 7'd5, $urandom);
        write_coef(0, 7'($urandom_range(81, 127)), $urandom);
        for (int f = 0; f < 6; f++) begin
            for (int k = 1; k <= N; k++) xs[k] = 7'($urandom);
            send_frame(30);
            get_result((f == 0) ? 5 : int'($urandom_range(4)), 0, 32'h0, "rand", lat);
            for (int j = 0; j < 3; j++) write_coef(0, 7'($urandom_range(80)), $urandom);
        end

        // Two channels, four features.
        th2[0] = '{0, 1, 2, 3, 4};
        th2[1] = '{1, -1, -1, -1, -1};
        xv2    = '{10, 20, 30, 40};
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 5; a++) write2(1'(c), 3'(a), 32'(th2[c][a]));
        chk("mc_idle_busy", busy2, 0);
        x_valid2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            x_data2 = 7'(xv2[k]);
            tick();
        end
        x_valid2 = 1'b0;
        lat = 0;
        while (!res_valid2 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("mc_latency", 64'(lat), 64'd2);
        chk("mc_ch0", res_data2[31:0], 32'd300);
        chk("mc_ch1", res_data2[63:32], 32'd65436);
        tick();
        res_ready2 = 1'b1;
        tick();
        res_ready2 = 1'b0;
        @(negedge clk);
        chk("mc_done_busy", busy2, 0);
        chk("mc_done_valid", res_valid2, 0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
